// File: rtl/fsa_bank_ctl.sv
// Double-buffer bank scheduler between the column writer and the fsa stream reader.
// Owns bank states, issues wr_start/fsync, and counts dropped frames and missed requests.
module fsa_bank_ctl #(
  parameter int unsigned C_IMG_HW = 12,
  parameter int unsigned C_IMG_WW = 12,
  parameter int unsigned C_CNT_W  = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [C_IMG_HW-1:0] cfg_height,
  input  logic [C_IMG_WW-1:0] cfg_width,
  input  logic                wr_done,
  output logic                wr_start,
  output logic                wr_bank,
  output logic                wr_active,
  input  logic                frame_req,
  input  logic                rd_done,
  output logic                fsync,
  output logic                rd_bank,
  output logic                rd_active,
  output logic [C_IMG_HW-1:0] height,
  output logic [C_IMG_WW-1:0] width,
  output logic [C_CNT_W-1:0]  drop_cnt,
  output logic [C_CNT_W-1:0]  miss_cnt,
  output logic                err
);

  typedef enum logic [1:0] {
    B_FREE    = 2'd0,
    B_WRITING = 2'd1,
    B_READY   = 2'd2,
    B_READING = 2'd3
  } bank_st_e;

  bank_st_e             bank_q [2];
  bank_st_e             bank_d [2];
  logic                 wr_start_q, wr_start_d;
  logic                 wr_bank_q, wr_bank_d;
  logic                 wr_active_q, wr_active_d;
  logic                 fsync_q, fsync_d;
  logic                 rd_bank_q, rd_bank_d;
  logic                 rd_active_q, rd_active_d;
  logic [C_IMG_HW-1:0]  height_q, height_d;
  logic [C_IMG_WW-1:0]  width_q, width_d;
  logic [C_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [C_CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic                 err_q, err_d;

  logic                 any_ready_c, any_free_c;
  logic                 rd_accept_c, rd_sel_c;
  logic                 wr_other_c;

  always_comb begin
    any_ready_c = (bank_q[0] == B_READY) || (bank_q[1] == B_READY);
    any_free_c  = (bank_q[0] == B_FREE)  || (bank_q[1] == B_FREE);
    wr_other_c  = ~wr_bank_q;
  end

  // Next-state: reader first, so a READY bank taken this cycle is never also dropped.
  always_comb begin
    bank_d      = bank_q;
    wr_start_d  = 1'b0;
    wr_bank_d   = wr_bank_q;
    wr_active_d = wr_active_q;
    fsync_d     = 1'b0;
    rd_bank_d   = rd_bank_q;
    rd_active_d = rd_active_q;
    height_d    = height_q;
    width_d     = width_q;
    drop_cnt_d  = drop_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_d       = err_q;
    rd_accept_c = 1'b0;
    rd_sel_c    = 1'b0;

    if (frame_req) begin
      if (!rd_active_q && any_ready_c) begin
        rd_accept_c = 1'b1;
        rd_sel_c    = (bank_q[0] == B_READY) ? 1'b0 : 1'b1;
      end else begin
        miss_cnt_d = miss_cnt_q + C_CNT_W'(1);
      end
    end

    if (rd_accept_c) begin
      bank_d[rd_sel_c] = B_READING;
      rd_bank_d        = rd_sel_c;
      rd_active_d      = 1'b1;
      height_d         = cfg_height;
      width_d          = cfg_width;
      fsync_d          = 1'b1;
    end

    if (rd_done) begin
      if (rd_active_q) begin
        bank_d[rd_bank_q] = B_FREE;
        rd_active_d       = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end

    if (wr_done && !wr_active_q) begin
      err_d = 1'b1;
    end

    if (wr_done && wr_active_q) begin
      bank_d[wr_bank_q] = B_READY;
      wr_active_d       = 1'b0;
      // Newest frame wins: discard an unread older frame
      if (bank_q[wr_other_c] == B_READY && !(rd_accept_c && rd_sel_c == wr_other_c)) begin
        bank_d[wr_other_c] = B_FREE;
        drop_cnt_d         = drop_cnt_q + C_CNT_W'(1);
      end
    end else if (!wr_active_q && any_free_c) begin
      wr_bank_d   = (bank_q[0] == B_FREE) ? 1'b0 : 1'b1;
      bank_d[wr_bank_d] = B_WRITING;
      wr_active_d = 1'b1;
      wr_start_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      bank_q[0]   <= B_FREE;
      bank_q[1]   <= B_FREE;
      wr_start_q  <= 1'b0;
      wr_bank_q   <= 1'b0;
      wr_active_q <= 1'b0;
      fsync_q     <= 1'b0;
      rd_bank_q   <= 1'b0;
      rd_active_q <= 1'b0;
      height_q    <= '0;
      width_q     <= '0;
      drop_cnt_q  <= '0;
      miss_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      bank_q[0]   <= bank_d[0];
      bank_q[1]   <= bank_d[1];
      wr_start_q  <= wr_start_d;
      wr_bank_q   <= wr_bank_d;
      wr_active_q <= wr_active_d;
      fsync_q     <= fsync_d;
      rd_bank_q   <= rd_bank_d;
      rd_active_q <= rd_active_d;
      height_q    <= height_d;
      width_q     <= width_d;
      drop_cnt_q  <= drop_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      err_q       <= err_d;
    end
  end

  assign wr_start  = wr_start_q;
  assign wr_bank   = wr_bank_q;
  assign wr_active = wr_active_q;
  assign fsync     = fsync_q;
  assign rd_bank   = rd_bank_q;
  assign rd_active = rd_active_q;
  assign height    = height_q;
  assign width     = width_q;
  assign drop_cnt  = drop_cnt_q;
  assign miss_cnt  = miss_cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_fsa_bank_ctl.sv
// Scoreboard bench for fsa_bank_ctl: directed stimulus pushes expected wr_start/fsync
// events; a negedge monitor pops and compares them, plus direct status checks.
module tb_fsa_bank_ctl;

  logic        clk = 1'b0;
  logic        resetn;
  logic [11:0] cfg_height, cfg_width;
  logic        wr_done, frame_req, rd_done;
  logic        wr_start, wr_bank, wr_active, fsync, rd_bank, rd_active, err;
  logic [11:0] height, width;
  logic [15:0] drop_cnt, miss_cnt;

  int nerr = 0;
  int nchk = 0;
  int cyc  = 0;

  typedef struct {
    logic b;
    int   at;
    int   h;
    int   w;
  } ev_t;

  ev_t wsq[$];
  ev_t fsq[$];
  ev_t ws_e, fs_e;

  fsa_bank_ctl #(.C_IMG_HW(12), .C_IMG_WW(12), .C_CNT_W(16)) dut (
    .clk(clk), .resetn(resetn), .cfg_height(cfg_height), .cfg_width(cfg_width),
    .wr_done(wr_done), .wr_start(wr_start), .wr_bank(wr_bank), .wr_active(wr_active),
    .frame_req(frame_req), .rd_done(rd_done), .fsync(fsync), .rd_bank(rd_bank),
    .rd_active(rd_active), .height(height), .width(width), .drop_cnt(drop_cnt),
    .miss_cnt(miss_cnt), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every wr_start/fsync pulse must match the oldest expected event
  always @(negedge clk) begin
    if (wr_start === 1'b1) begin
      if (wsq.size() == 0) begin
        chk("unexpected_wr_start", 32'(1), 32'(0));
      end else begin
        ws_e = wsq.pop_front();
        chk("wr_start_cycle", 32'(cyc), 32'(ws_e.at));
        chk("wr_start_bank", 32'(wr_bank), 32'(ws_e.b));
      end
    end
    if (fsync === 1'b1) begin
      if (fsq.size() == 0) begin
        chk("unexpected_fsync", 32'(1), 32'(0));
      end else begin
        fs_e = fsq.pop_front();
        chk("fsync_cycle", 32'(cyc), 32'(fs_e.at));
        chk("fsync_rd_bank", 32'(rd_bank), 32'(fs_e.b));
        chk("fsync_height", 32'(height), 32'(fs_e.h));
        chk("fsync_width", 32'(width), 32'(fs_e.w));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_ws(input logic b, input int dly);
    ev_t e;
    e.b = b; e.at = cyc + dly; e.h = 0; e.w = 0;
    wsq.push_back(e);
  endtask

  task automatic exp_fs(input logic b, input int h, input int w);
    ev_t e;
    e.b = b; e.at = cyc + 1; e.h = h; e.w = w;
    fsq.push_back(e);
  endtask

  task automatic pulse(input logic wd, input logic fr, input logic rd);
    wr_done = wd; frame_req = fr; rd_done = rd;
    step(1);
    wr_done = 1'b0; frame_req = 1'b0; rd_done = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wr_start"}, 32'(wr_start), 32'(0));
    chk({tag, "_wr_bank"}, 32'(wr_bank), 32'(0));
    chk({tag, "_wr_active"}, 32'(wr_active), 32'(0));
    chk({tag, "_fsync"}, 32'(fsync), 32'(0));
    chk({tag, "_rd_bank"}, 32'(rd_bank), 32'(0));
    chk({tag, "_rd_active"}, 32'(rd_active), 32'(0));
    chk({tag, "_height"}, 32'(height), 32'(0));
    chk({tag, "_width"}, 32'(width), 32'(0));
    chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(0));
    chk({tag, "_miss_cnt"}, 32'(miss_cnt), 32'(0));
    chk({tag, "_err"}, 32'(err), 32'(0));
  endtask

  initial begin
    resetn = 1'b0; wr_done = 1'b0; frame_req = 1'b0; rd_done = 1'b0;
    cfg_height = 12'd0; cfg_width = 12'd0;
    step(3);
    chk_reset_vals("reset");

    // Start-up: release in cycle 0, wr_done at 10, frame_req at 12
    resetn = 1'b1;
    exp_ws(1'b0, 1);
    step(10);
    exp_ws(1'b1, 2);
    pulse(1'b1, 1'b0, 1'b0);
    step(1);
    cfg_height = 12'd720; cfg_width = 12'd1280;
    exp_fs(1'b0, 720, 1280);
    pulse(1'b0, 1'b1, 1'b0);
    cfg_height = 12'd100; cfg_width = 12'd200;
    step(3);
    chk("geom_hold_height", 32'(height), 32'(720));
    chk("geom_hold_width", 32'(width), 32'(1280));
    chk("startup_rd_active", 32'(rd_active), 32'(1));

    // Stall: reader on bank 0, writer completes bank 1
    pulse(1'b1, 1'b0, 1'b0);
    step(4);
    chk("stall_wr_active", 32'(wr_active), 32'(0));
    exp_ws(1'b0, 2);
    pulse(1'b0, 1'b0, 1'b1);
    chk("stall_rd_active_cleared", 32'(rd_active), 32'(0));
    chk("stall_rd_bank_held", 32'(rd_bank), 32'(0));
    step(3);

    // Misses: while reading, with nothing READY, and coincident with wr_done
    exp_fs(1'b1, 100, 200);
    pulse(1'b0, 1'b1, 1'b0);
    step(1);
    pulse(1'b0, 1'b1, 1'b0);
    step(1);
    pulse(1'b0, 1'b0, 1'b1);
    step(1);
    pulse(1'b0, 1'b1, 1'b0);
    step(1);
    exp_ws(1'b1, 2);
    pulse(1'b1, 1'b1, 1'b0);
    step(3);
    chk("miss_cnt", 32'(miss_cnt), 32'(3));
    chk("miss_drop_cnt", 32'(drop_cnt), 32'(0));

    // Drop: bank 0 READY unread when bank 1 completes
    exp_ws(1'b0, 2);
    pulse(1'b1, 1'b0, 1'b0);
    step(3);
    chk("drop_cnt", 32'(drop_cnt), 32'(1));
    cfg_height = 12'd300; cfg_width = 12'd400;
    exp_fs(1'b1, 300, 400);
    pulse(1'b0, 1'b1, 1'b0);
    step(2);

    // Protocol errors: rd_done while idle, then wr_done while unallocated
    pulse(1'b0, 1'b0, 1'b1);
    step(1);
    chk("err_clear_before", 32'(err), 32'(0));
    pulse(1'b0, 1'b0, 1'b1);
    step(1);
    chk("err_rd_idle", 32'(err), 32'(1));
    exp_ws(1'b1, 2);
    pulse(1'b1, 1'b0, 1'b0);
    step(2);
    exp_fs(1'b0, 300, 400);
    pulse(1'b0, 1'b1, 1'b0);
    step(1);
    pulse(1'b1, 1'b0, 1'b0);
    step(2);
    pulse(1'b1, 1'b0, 1'b0);
    step(2);
    chk("err_sticky", 32'(err), 32'(1));
    chk("err_wr_active", 32'(wr_active), 32'(0));
    chk("err_wr_bank", 32'(wr_bank), 32'(1));
    chk("err_rd_active", 32'(rd_active), 32'(1));
    chk("err_rd_bank", 32'(rd_bank), 32'(0));
    chk("err_drop_cnt", 32'(drop_cnt), 32'(1));
    chk("err_miss_cnt", 32'(miss_cnt), 32'(3));

    // Mid-frame reset for one cycle while reading
    resetn = 1'b0;
    step(1);
    resetn = 1'b1;
    chk_reset_vals("midreset");
    exp_ws(1'b0, 1);
    step(2);
    chk("restart_wr_active", 32'(wr_active), 32'(1));
    exp_ws(1'b1, 2);
    pulse(1'b1, 1'b0, 1'b0);
    step(1);
    cfg_height = 12'd5; cfg_width = 12'd6;
    exp_fs(1'b0, 5, 6);
    pulse(1'b0, 1'b1, 1'b0);
    step(3);

    chk("pending_wr_start", 32'(wsq.size()), 32'(0));
    chk("pending_fsync", 32'(fsq.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
